// File: rtl/palette_ram.sv
// -----------------------------------------------------------------------------
// palette_ram
//   Colour palette lookup with NUM_RD independent read channels, one write
//   port and an optional frame-based brightness fade.
//
//   Build option: PALETTE_FADE_EN
//     defined   - fade FSM (IDLE/RUN) and per-channel brightness scaling
//     undefined - fade inputs ignored, fade_level = 16, fade_busy/fade_done = 0,
//                 second read stage is a plain register (same 2-cycle latency)
//
//   Ports
//     clk, reset        sole clock, synchronous active-high reset
//     rd_valid_in       per-channel lookup request
//     rd_idx            packed indices, channel k at [k*IDX_W +: IDX_W]
//     rd_valid_out      per-channel result valid, two cycles after request
//     red/green/blue    packed per-channel colour, same packing as rd_idx
//     wr_en/wr_idx      palette write strobe and address
//     wr_rgb            write data {r,g,b}
//     frame_tick        one pulse per video frame (fade step)
//     fade_start        fade request, fade_dir 0 = to black, 1 = to full
//     fade_level        current brightness 0..16
//     fade_busy         high while a fade is running
//     fade_done         one-cycle pulse when a fade completes
// -----------------------------------------------------------------------------
module palette_ram #(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 4,
  parameter int NUM_RD  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_RD-1:0]         rd_valid_in,
  input  logic [NUM_RD*IDX_W-1:0]   rd_idx,
  output logic [NUM_RD-1:0]         rd_valid_out,
  output logic [NUM_RD*COLOR_W-1:0] red,
  output logic [NUM_RD*COLOR_W-1:0] green,
  output logic [NUM_RD*COLOR_W-1:0] blue,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [3*COLOR_W-1:0]      wr_rgb,
  input  logic                      frame_tick,
  input  logic                      fade_start,
  input  logic                      fade_dir,
  output logic [4:0]                fade_level,
  output logic                      fade_busy,
  output logic                      fade_done
);

  localparam int DEPTH = 2**IDX_W;
  localparam int RGB_W = 3*COLOR_W;

  // A 4-bit default nibble lands in the channel MSBs: zero-filled below when
  // the channel is wider, truncated to its top bits when narrower.
  function automatic logic [COLOR_W-1:0] expand_nibble(input logic [3:0] n);
    logic [COLOR_W+3:0] wide;
    wide = {n, {COLOR_W{1'b0}}};
    return wide[COLOR_W+3 -: COLOR_W];
  endfunction

  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    logic [11:0] nib;
    case (idx)
      0:       nib = 12'h520;
      1:       nib = 12'h6AF;
      2:       nib = 12'h940;
      3:       nib = 12'hFFF;
      4:       nib = 12'h000;
      default: nib = 12'h6AF;
    endcase
    return {expand_nibble(nib[11:8]), expand_nibble(nib[7:4]), expand_nibble(nib[3:0])};
  endfunction

  logic [RGB_W-1:0]  palette [DEPTH];
  logic [NUM_RD-1:0] s1_valid;
  logic [RGB_W-1:0]  s1_rgb  [NUM_RD];
  logic [RGB_W-1:0]  s2_next [NUM_RD];

  // Palette storage. Reset reloads the default colours; a write lands at the
  // edge, so a same-cycle read still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        palette[i] <= default_entry(i);
      end
    end else if (wr_en) begin
      palette[wr_idx] <= wr_rgb;
    end
  end

  // First read stage: every channel looks up its own index each cycle, no
  // arbitration, identical indices allowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= '0;
      for (int k = 0; k < NUM_RD; k++) begin
        s1_rgb[k] <= '0;
      end
    end else begin
      s1_valid <= rd_valid_in;
      for (int k = 0; k < NUM_RD; k++) begin
        s1_rgb[k] <= palette[rd_idx[k*IDX_W +: IDX_W]];
      end
    end
  end

`ifdef PALETTE_FADE_EN

  typedef enum logic {IDLE, RUN} fade_state_t;

  fade_state_t state, state_next;
  logic        dir_q, dir_next;
  logic [4:0]  level_next;
  logic        done_next;
  logic        eff_dir;
  logic [4:0]  eff_target;
  logic [4:0]  start_target;

  // Brightness scaling at full width: c*16>>4 == c, so no overflow is possible.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [4:0] lvl);
    logic [COLOR_W+4:0] prod;
    prod = {5'd0, c} * {{COLOR_W{1'b0}}, lvl};
    return prod[COLOR_W+3:4];
  endfunction

  // Fade state register; reset forces full brightness and idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      fade_level <= 5'd16;
      fade_done  <= 1'b0;
    end else begin
      state      <= state_next;
      dir_q      <= dir_next;
      fade_level <= level_next;
      fade_done  <= done_next;
    end
  end

  // Fade next-state. A restart in RUN takes the new direction before any
  // coincident frame step, and the abandoned fade never reports done.
  always_comb begin
    state_next   = state;
    dir_next     = dir_q;
    level_next   = fade_level;
    done_next    = 1'b0;
    eff_dir      = dir_q;
    eff_target   = 5'd0;
    start_target = fade_dir ? 5'd16 : 5'd0;
    case (state)
      IDLE: begin
        if (fade_start) begin
          if (fade_level == start_target) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
            dir_next   = fade_dir;
          end
        end
      end
      RUN: begin
        eff_dir    = fade_start ? fade_dir : dir_q;
        eff_target = eff_dir ? 5'd16 : 5'd0;
        dir_next   = eff_dir;
        if (fade_level == eff_target) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (frame_tick) begin
          level_next = eff_dir ? fade_level + 5'd1 : fade_level - 5'd1;
          if (level_next == eff_target) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fade_busy = (state == RUN);

  // Second-stage data: each channel scaled by the current brightness.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      s2_next[k] = {scale(s1_rgb[k][3*COLOR_W-1 -: COLOR_W], fade_level),
                    scale(s1_rgb[k][2*COLOR_W-1 -: COLOR_W], fade_level),
                    scale(s1_rgb[k][COLOR_W-1   -: COLOR_W], fade_level)};
    end
  end

`else

  logic unused_fade_inputs;

  assign fade_level         = 5'd16;
  assign fade_busy          = 1'b0;
  assign fade_done          = 1'b0;
  assign unused_fade_inputs = ^{frame_tick, fade_start, fade_dir};

  // Without fading the second stage just carries the looked-up colour.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      s2_next[k] = s1_rgb[k];
    end
  end

`endif

  // Second read stage: a channel's colour only updates when its result is
  // valid, otherwise the previous colour is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_out <= '0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
    end else begin
      rd_valid_out <= s1_valid;
      for (int k = 0; k < NUM_RD; k++) begin
        if (s1_valid[k]) begin
          red[k*COLOR_W +: COLOR_W]   <= s2_next[k][3*COLOR_W-1 -: COLOR_W];
          green[k*COLOR_W +: COLOR_W] <= s2_next[k][2*COLOR_W-1 -: COLOR_W];
          blue[k*COLOR_W +: COLOR_W]  <= s2_next[k][COLOR_W-1   -: COLOR_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_palette_ram.sv
// -----------------------------------------------------------------------------
// tb_palette_ram
//   Self-checking bench for palette_ram with default parameters
//   (IDX_W=4, COLOR_W=4, NUM_RD=2). Fade checks follow PALETTE_FADE_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_palette_ram;

  localparam int IDX_W   = 4;
  localparam int COLOR_W = 4;
  localparam int NUM_RD  = 2;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_valid_in;
  logic [7:0]  rd_idx;
  logic [1:0]  rd_valid_out;
  logic [7:0]  red, green, blue;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [11:0] wr_rgb;
  logic        frame_tick, fade_start, fade_dir;
  logic [4:0]  fade_level;
  logic        fade_busy, fade_done;

  int compared   = 0;
  int mismatched = 0;

  palette_ram #(.IDX_W(IDX_W), .COLOR_W(COLOR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .reset(reset),
    .rd_valid_in(rd_valid_in), .rd_idx(rd_idx),
    .rd_valid_out(rd_valid_out), .red(red), .green(green), .blue(blue),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
    .fade_level(fade_level), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [3:0]  i0;
    logic [3:0]  i1;
    logic        we;
    logic [3:0]  wi;
    logic [11:0] wd;
    logic        tick;
    logic        start;
    logic        dir;
  } stim_t;

  typedef struct {
    logic [1:0]  v;
    logic [11:0] c0;
    logic [11:0] c1;
  } rd_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  ev;
    logic [11:0] ec0;
    logic [11:0] ec1;
  } vec_t;

  // Reference model state: palette contents, requests in flight, expected
  // outputs and the brightness level.
  logic [11:0] pal_m [DEPTH];
  rd_t         rdq [$];
  logic [1:0]  exp_v;
  logic [11:0] exp_c0, exp_c1;
  int          lvl_m;
  bit          busy_m, dir_m, done_m;

  function automatic logic [11:0] defaultColour(input int idx);
    case (idx)
      0:       return 12'h520;
      1:       return 12'h6AF;
      2:       return 12'h940;
      3:       return 12'hFFF;
      4:       return 12'h000;
      default: return 12'h6AF;
    endcase
  endfunction

  function automatic logic [11:0] scaleRgb(input logic [11:0] c, input int lvl);
    int r, g, b;
    r = int'(c[11:8]) * lvl / 16;
    g = int'(c[7:4])  * lvl / 16;
    b = int'(c[3:0])  * lvl / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 1'b0; s.rv = 2'b00; s.i0 = 4'd0; s.i1 = 4'd0;
    s.we = 1'b0; s.wi = 4'd0; s.wd = 12'h000;
    s.tick = 1'b0; s.start = 1'b0; s.dir = 1'b0;
    return s;
  endfunction

  function automatic logic [11:0] chColour(input int ch);
    return {red[ch*4 +: 4], green[ch*4 +: 4], blue[ch*4 +: 4]};
  endfunction

  // Advance the reference model by one clock edge with the given inputs.
  task automatic modelStep(input stim_t s);
    rd_t head;
    int  tgt;
    if (s.rst) begin
      for (int i = 0; i < DEPTH; i++) pal_m[i] = defaultColour(i);
      rdq.delete();
      head.v = 2'b00; head.c0 = 12'h000; head.c1 = 12'h000;
      rdq.push_back(head);
      exp_v = 2'b00; exp_c0 = 12'h000; exp_c1 = 12'h000;
      lvl_m = 16; busy_m = 1'b0; dir_m = 1'b0; done_m = 1'b0;
    end else begin
      head  = rdq.pop_front();
      exp_v = head.v;
      if (head.v[0]) exp_c0 = scaleRgb(head.c0, lvl_m);
      if (head.v[1]) exp_c1 = scaleRgb(head.c1, lvl_m);
      head.v = s.rv; head.c0 = pal_m[s.i0]; head.c1 = pal_m[s.i1];
      rdq.push_back(head);
      if (s.we) pal_m[s.wi] = s.wd;
`ifdef PALETTE_FADE_EN
      done_m = 1'b0;
      if (!busy_m) begin
        if (s.start) begin
          if (lvl_m == (s.dir ? 16 : 0)) done_m = 1'b1;
          else begin busy_m = 1'b1; dir_m = s.dir; end
        end
      end else begin
        if (s.start) dir_m = s.dir;
        tgt = dir_m ? 16 : 0;
        if (lvl_m == tgt) begin
          busy_m = 1'b0; done_m = 1'b1;
        end else if (s.tick) begin
          lvl_m = dir_m ? lvl_m + 1 : lvl_m - 1;
          if (lvl_m == tgt) begin busy_m = 1'b0; done_m = 1'b1; end
        end
      end
`endif
    end
  endtask

  // Drive one cycle of inputs, step the model, and land 1 ns after the edge.
  task automatic applyStimulus(input stim_t s);
    reset       = s.rst;
    rd_valid_in = s.rv;
    rd_idx      = {s.i1, s.i0};
    wr_en       = s.we;
    wr_idx      = s.wi;
    wr_rgb      = s.wd;
    frame_tick  = s.tick;
    fade_start  = s.start;
    fade_dir    = s.dir;
    modelStep(s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, " valid"}, 32'(rd_valid_out), 32'(exp_v));
    checkOutput({tag, " ch0"},   32'(chColour(0)),  32'(exp_c0));
    checkOutput({tag, " ch1"},   32'(chColour(1)),  32'(exp_c1));
    checkOutput({tag, " level"}, 32'(fade_level),   32'(lvl_m));
    checkOutput({tag, " busy"},  32'(fade_busy),    32'(busy_m));
    checkOutput({tag, " done"},  32'(fade_done),    32'(done_m));
  endtask

  // Main sequence: reset, table reads, corner sequences, then random traffic.
  initial begin
    stim_t s;
    vec_t  v;
    vec_t  tbl [$];
    int    doneCount;

    $display("[TB] start");

    // Reset with write/read requests present: both must be ignored.
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    s.we = 1'b1; s.wi = 4'd0; s.wd = 12'h0F0; s.rv = 2'b11; s.start = 1'b1;
    applyStimulus(s);
    checkOutput("reset valid", 32'(rd_valid_out), 32'd0);
    checkOutput("reset red",   32'(red),          32'd0);
    checkOutput("reset green", 32'(green),        32'd0);
    checkOutput("reset blue",  32'(blue),         32'd0);
    checkOutput("reset level", 32'(fade_level),   32'd16);
    checkOutput("reset busy",  32'(fade_busy),    32'd0);
    checkOutput("reset done",  32'(fade_done),    32'd0);

    // Table: default palette on both channels, same index, and hold on idle channel.
    for (int i = 0; i < 16; i++) begin
      v.s = idleStim(); v.s.rv = 2'b11; v.s.i0 = 4'(i); v.s.i1 = 4'(15 - i);
      v.ev = 2'b11; v.ec0 = defaultColour(i); v.ec1 = defaultColour(15 - i);
      tbl.push_back(v);
    end
    v.s = idleStim(); v.s.rv = 2'b11; v.s.i0 = 4'd2; v.s.i1 = 4'd2;
    v.ev = 2'b11; v.ec0 = 12'h940; v.ec1 = 12'h940;
    tbl.push_back(v);
    v.s = idleStim(); v.s.rv = 2'b01; v.s.i0 = 4'd4; v.s.i1 = 4'd9;
    v.ev = 2'b01; v.ec0 = 12'h000; v.ec1 = 12'h940;
    tbl.push_back(v);
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) applyStimulus(tbl[i].s);
      else applyStimulus(idleStim());
      if (i >= 1) begin
        checkOutput($sformatf("tbl%0d valid", i - 1), 32'(rd_valid_out), 32'(tbl[i-1].ev));
        checkOutput($sformatf("tbl%0d ch0", i - 1),   32'(chColour(0)),  32'(tbl[i-1].ec0));
        checkOutput($sformatf("tbl%0d ch1", i - 1),   32'(chColour(1)),  32'(tbl[i-1].ec1));
      end
    end

    // Read during write to the same index returns the old entry, then the new one.
    s = idleStim(); s.rv = 2'b01; s.i0 = 4'd3; s.we = 1'b1; s.wi = 4'd3; s.wd = 12'h123;
    applyStimulus(s);
    s = idleStim(); s.rv = 2'b01; s.i0 = 4'd3;
    applyStimulus(s);
    checkOutput("rdw old valid", 32'(rd_valid_out[0]), 32'd1);
    checkOutput("rdw old", 32'(chColour(0)), 32'h0FFF);
    applyStimulus(idleStim());
    checkOutput("rdw new", 32'(chColour(0)), 32'h0123);

    // Reset in the middle of a write restores the defaults.
    s = idleStim(); s.rst = 1'b1; s.we = 1'b1; s.wi = 4'd0; s.wd = 12'h0F0; s.rv = 2'b11;
    applyStimulus(s);
    s = idleStim(); s.rv = 2'b11; s.i0 = 4'd3; s.i1 = 4'd0;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("rst-wr idx3", 32'(chColour(0)), 32'h0FFF);
    checkOutput("rst-wr idx0", 32'(chColour(1)), 32'h0520);

`ifdef PALETTE_FADE_EN
    // Fade to black over 16 ticks, reading index 3 at level 8 and level 0.
    s = idleStim(); s.rst = 1'b1; applyStimulus(s);
    s = idleStim(); s.start = 1'b1; s.dir = 1'b0; applyStimulus(s);
    checkOutput("fade0 busy", 32'(fade_busy), 32'd1);
    checkOutput("fade0 start level", 32'(fade_level), 32'd16);
    doneCount = 0;
    for (int k = 0; k < 16; k++) begin
      s = idleStim(); s.tick = 1'b1; applyStimulus(s);
      checkOutput("fade0 level", 32'(fade_level), 32'(15 - k));
      checkOutput("fade0 done", 32'(fade_done), 32'(k == 15));
      if (fade_done) doneCount++;
      if (k == 7 || k == 15) begin
        s = idleStim(); s.rv = 2'b01; s.i0 = 4'd3; applyStimulus(s);
        if (fade_done) doneCount++;
        applyStimulus(idleStim());
        if (fade_done) doneCount++;
        checkOutput("fade0 idx3", 32'(chColour(0)), 32'(scaleRgb(12'hFFF, 15 - k)));
      end
    end
    checkOutput("fade0 busy end", 32'(fade_busy), 32'd0);
    checkOutput("fade0 done count", 32'(doneCount), 32'd1);

    // Reverse at level 5: the abandoned fade never reports done.
    s = idleStim(); s.rst = 1'b1; applyStimulus(s);
    s = idleStim(); s.start = 1'b1; applyStimulus(s);
    doneCount = 0;
    for (int k = 0; k < 11; k++) begin
      s = idleStim(); s.tick = 1'b1; applyStimulus(s);
      if (fade_done) doneCount++;
    end
    checkOutput("rev level5", 32'(fade_level), 32'd5);
    s = idleStim(); s.start = 1'b1; s.dir = 1'b1; applyStimulus(s);
    if (fade_done) doneCount++;
    checkOutput("rev busy", 32'(fade_busy), 32'd1);
    for (int k = 0; k < 11; k++) begin
      s = idleStim(); s.tick = 1'b1; applyStimulus(s);
      checkOutput("rev done", 32'(fade_done), 32'(k == 10));
      if (fade_done) doneCount++;
    end
    checkOutput("rev level16", 32'(fade_level), 32'd16);
    checkOutput("rev done count", 32'(doneCount), 32'd1);

    // Already at target: immediate done, stays idle.
    s = idleStim(); s.start = 1'b1; s.dir = 1'b1; applyStimulus(s);
    checkOutput("at-target done", 32'(fade_done), 32'd1);
    checkOutput("at-target busy", 32'(fade_busy), 32'd0);

    // Restart coincident with a tick applies the new direction, then steps.
    s = idleStim(); s.start = 1'b1; s.dir = 1'b0; applyStimulus(s);
    s = idleStim(); s.tick = 1'b1; applyStimulus(s);
    checkOutput("coinc level15", 32'(fade_level), 32'd15);
    s = idleStim(); s.tick = 1'b1; s.start = 1'b1; s.dir = 1'b1; applyStimulus(s);
    checkOutput("coinc level16", 32'(fade_level), 32'd16);
    checkOutput("coinc done", 32'(fade_done), 32'd1);
    checkOutput("coinc busy", 32'(fade_busy), 32'd0);

    // Reset mid-fade at level 7.
    s = idleStim(); s.start = 1'b1; applyStimulus(s);
    for (int k = 0; k < 9; k++) begin
      s = idleStim(); s.tick = 1'b1; applyStimulus(s);
    end
    checkOutput("midrst level7", 32'(fade_level), 32'd7);
    s = idleStim(); s.rst = 1'b1; s.tick = 1'b1; s.start = 1'b1; s.we = 1'b1; s.wi = 4'd3;
    applyStimulus(s);
    checkOutput("midrst level", 32'(fade_level), 32'd16);
    checkOutput("midrst busy", 32'(fade_busy), 32'd0);
    for (int i = 0; i <= 16; i++) begin
      s = idleStim();
      if (i < 16) begin s.rv = 2'b01; s.i0 = 4'(i); end
      applyStimulus(s);
      if (i >= 1) checkOutput($sformatf("midrst pal%0d", i - 1), 32'(chColour(0)),
                              32'(defaultColour(i - 1)));
    end
`else
    // Fade inputs have no effect: level stays 16, no busy, no done.
    s = idleStim(); s.rst = 1'b1; applyStimulus(s);
    for (int k = 0; k < 20; k++) begin
      s = idleStim(); s.tick = 1'b1; s.start = (k % 5 == 0); s.dir = k[0];
      applyStimulus(s);
      checkOutput("nofade level", 32'(fade_level), 32'd16);
      checkOutput("nofade busy",  32'(fade_busy),  32'd0);
      checkOutput("nofade done",  32'(fade_done),  32'd0);
    end
    s = idleStim(); s.rv = 2'b01; s.i0 = 4'd3; applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("nofade idx3", 32'(chColour(0)), 32'h0FFF);
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      s.rst   = ($urandom_range(99) == 0);
      s.rv    = 2'($urandom_range(3));
      s.i0    = 4'($urandom_range(15));
      s.i1    = ($urandom_range(3) == 0) ? s.i0 : 4'($urandom_range(15));
      s.we    = ($urandom_range(3) == 0);
      s.wi    = ($urandom_range(1) == 0) ? s.i0 : 4'($urandom_range(15));
      s.wd    = 12'($urandom_range(4095));
      s.tick  = ($urandom_range(2) == 0);
      s.start = ($urandom_range(15) == 0);
      s.dir   = 1'($urandom_range(1));
      applyStimulus(s);
      checkAgainstModel("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
